alu_mdu_unit: RTL and testbench
===============================

# alu_mdu_unit

Parametrised execution unit combining a single-cycle integer ALU with an iterative multiply/divide engine behind a valid/ready handshake. It is the next-generation replacement for the fixed 32-bit, 3-bit-select combinational ALU. It sits in the EX stage, with operands coming from the issue logic and results going to the writeback/HI-LO path. Only one operation is in flight at a time, and results are held in an output register until they are consumed.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 8. Shift amount is b[$clog2(WIDTH)-1:0].
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of in-flight/held operation.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MULTU, 12 MULT, 13 DIVU, 14 DIV, 15 reserved.
- in_a, in_b  in  WIDTH  operands.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_lo  out  WIDTH  ALU result / product low / quotient.
- out_hi  out  WIDTH  product high / remainder; 0 for ALU ops.
- out_zero  out  1  out_lo == 0.
- out_ovf  out  1  signed overflow on ADD/SUB; 0 otherwise.
- out_dbz  out  1  divide by zero on DIVU/DIV.
- busy  out  1  state == BUSY.

## Operation
- States: IDLE, BUSY.
- in_ready = (state == IDLE) && !flush && (!out_valid || out_ready).
- Accept = in_valid && in_ready.
- Accept of ALU op (0–10, 15): the result is written into the output register at the same edge, and out_valid = 1. Op 15 gives lo = hi = 0 and all flags 0.
- SLT/SLTU: lo = {WIDTH-1 zeros, cmp}. SRA sign-fills. ADD/SUB wrap modulo 2^WIDTH.
- Accept of MULTU/MULT: operands are latched as magnitudes, signed-converted for MULT. The sign fix is recorded. Count = WIDTH. Go BUSY.
  - One shift-add step per cycle.
- Accept of DIVU/DIV with b ≠ 0: operands are latched as magnitudes and the signs are recorded. Go BUSY.
  - One restoring-division step per cycle.
  - Quotient is negated if the signs differ. Remainder takes the dividend's sign.
- DIV of MIN / −1: lo = MIN, hi = 0, out_ovf = 0. This falls out of the magnitude algorithm.
- Divide by zero: no BUSY. The result is registered at the accept edge with lo = all-ones, hi = in_a, out_dbz = 1.
- BUSY: count decrements each edge. At the edge where count goes 1→0 the final step completes, sign fix-up is applied, the result is loaded, out_valid = 1, and state returns to IDLE.
- Output handshake: out_valid && out_ready at an edge clears out_valid, unless a new ALU/dbz accept at the same edge reloads it. Back-to-back single-cycle ops therefore sustain one per cycle.
- Output registers hold their value while out_valid && !out_ready.
- flush: at the edge, state → IDLE, count → 0, out_valid → 0. No accept occurs in a flush cycle. Data registers need not clear.

## Timing
- Reset (async, resetn low): state IDLE, out_valid 0, out_lo 0, out_hi 0, out_zero 1, out_ovf 0, out_dbz 0, busy 0, count 0.
- in_ready is 1 after release, provided flush is low.
- ALU op / divide by zero: accepted at edge E0, out_valid visible after E0. Latency 1.
- MUL/DIV: accepted at E0, busy visible after E0. Result and out_valid visible after E_WIDTH, where busy drops. Latency WIDTH.
- in_ready is 0 throughout BUSY, and while out_valid && !out_ready.
- Reset asserted mid-BUSY: immediate return to reset values with no partial result.
- Flags (zero/ovf/dbz) are registered with and valid alongside out_lo/out_hi.

## Test plan
- WIDTH = 32, a = 0x30, b = 0x3E, sweep ops 0–10 with out_ready = 1, one per cycle:
  - ADD → 0x6E; SUB → 0xFFFFFFF2, ovf 0; AND → 0x30; OR → 0x3E; XOR → 0x0E; NOR → 0xFFFFFFC1; SLT → 1; SLL → 0x30<<30 = 0x00000000, zero 1.
  - Each op completes at latency 1 with no bubbles.
- ADD 0x7FFFFFFF + 1 → lo 0x80000000, ovf 1. SUB 5 − 5 → lo 0, zero 1.
- MULT 0xFFFFFFFE × 3 → hi 0xFFFFFFFF, lo 0xFFFFFFFA after exactly 32 cycles, with busy high for 32 cycles. MULTU of the same operands → hi 0x00000002, lo 0xFFFFFFFA.
- DIV −7 / 2 → lo 0xFFFFFFFD, hi 0xFFFFFFFF. DIVU 7 / 0 → lo 0xFFFFFFFF, hi 7, dbz 1, latency 1. DIV 0x80000000 / −1 → lo 0x80000000, hi 0.
- Backpressure: out_ready held 0 for 5 cycles after the ADD result → out_lo stable, in_ready 0 throughout. Raising out_ready together with a new in_valid → the next result loads in the same cycle.
- MULT accepted, flush at cycle 10 → busy 0 and out_valid 0 the next cycle, no result emitted. Repeat with resetn pulsed low at cycle 10 → all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_mdu_unit_if.sv
// alu_mdu_unit_if: issue/result handshake bundle for the EX-stage unit
// master = issue logic and writeback consumer, slave = the unit
interface alu_mdu_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] out_hi;
  logic             out_zero;
  logic             out_ovf;
  logic             out_dbz;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_lo, out_hi,
    input  out_zero, out_ovf, out_dbz
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_lo, out_hi,
    output out_zero, out_ovf, out_dbz
  );
endinterface

// File: rtl/alu_mdu_unit.sv
// alu_mdu_unit: single-cycle ALU plus iterative mul/div engine
// one op in flight; the result is held until consumed
module alu_mdu_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  output logic          busy,
  alu_mdu_unit_if.slave io
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam int M  = WIDTH - 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [M:0]    lo_q, lo_d;
  logic [M:0]    hi_q, hi_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic          dbz_q, dbz_d;
  logic          is_div_q, is_div_d;
  logic          neg_lo_q, neg_lo_d;
  logic          neg_hi_q, neg_hi_d;
  logic [M:0]    acc_q, acc_d;
  logic [M:0]    mq_q, mq_d;
  logic [M:0]    md_q, md_d;

  logic [3:0]    op;
  logic [M:0]    a, b;
  logic [SW-1:0] shamt;
  logic          is_md, is_dv, sgn, by_zero;
  logic          a_neg, b_neg;
  logic [M:0]    a_mag, b_mag;
  logic          in_ready, accept;

  assign op    = io.in_op;
  assign a     = io.in_a;
  assign b     = io.in_b;
  assign shamt = b[SW-1:0];

  assign is_md   = (op >= 4'd11) && (op <= 4'd14);
  assign is_dv   = (op == 4'd13) || (op == 4'd14);
  assign sgn     = (op == 4'd12) || (op == 4'd14);
  assign by_zero = is_dv && (b == '0);

  assign a_neg = sgn & a[M];
  assign b_neg = sgn & b[M];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign in_ready = (state_q == IDLE) && !flush &&
                    (!out_valid_q || io.out_ready);
  assign accept   = io.in_valid && in_ready;

  logic [M:0] add_r, sub_r, alu_lo;
  logic       alu_ovf;

  assign add_r = a + b;
  assign sub_r = a - b;

  always_comb begin
    alu_lo  = '0;
    alu_ovf = 1'b0;
    unique case (op)
      4'd0: begin
        alu_lo  = add_r;
        alu_ovf = (a[M] == b[M]) && (add_r[M] != a[M]);
      end
      4'd1: begin
        alu_lo  = sub_r;
        alu_ovf = (a[M] != b[M]) && (sub_r[M] != a[M]);
      end
      4'd2:    alu_lo = a & b;
      4'd3:    alu_lo = a | b;
      4'd4:    alu_lo = a ^ b;
      4'd5:    alu_lo = ~(a | b);
      4'd6:    alu_lo = {{M{1'b0}}, $signed(a) < $signed(b)};
      4'd7:    alu_lo = {{M{1'b0}}, a < b};
      4'd8:    alu_lo = a << shamt;
      4'd9:    alu_lo = a >> shamt;
      4'd10:   alu_lo = $unsigned($signed(a) >>> shamt);
      default: alu_lo = '0;
    endcase
  end

  // one shift-add or restoring-division step on the working regs
  logic [WIDTH:0] mul_sum, div_trial, div_diff;
  logic           div_ok;
  logic [M:0]     step_acc, step_mq;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, md_q} : '0);
    div_trial = {acc_q, mq_q[M]};
    div_diff  = div_trial - {1'b0, md_q};
    div_ok    = !div_diff[WIDTH];
    if (is_div_q) begin
      step_acc = div_ok ? div_diff[M:0] : div_trial[M:0];
      step_mq  = {mq_q[M-1:0], div_ok};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_mq  = {mul_sum[0], mq_q[M:1]};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [M:0]         md_lo, md_hi;

  always_comb begin
    prod     = {step_acc, step_mq};
    prod_fix = neg_lo_q ? -prod : prod;
    if (is_div_q) begin
      md_lo = neg_lo_q ? -step_mq : step_mq;
      md_hi = neg_hi_q ? -step_acc : step_acc;
    end else begin
      md_lo = prod_fix[M:0];
      md_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    is_div_d    = is_div_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    acc_d       = acc_q;
    mq_d        = mq_q;
    md_d        = md_q;

    if (out_valid_q && io.out_ready) out_valid_d = 1'b0;

    if (flush) begin
      state_d     = IDLE;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else if (state_q == BUSY) begin
      count_d = count_q - CW'(1);
      acc_d   = step_acc;
      mq_d    = step_mq;
      if (count_q == CW'(1)) begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        lo_d        = md_lo;
        hi_d        = md_hi;
        zero_d      = (md_lo == '0);
        ovf_d       = 1'b0;
        dbz_d       = 1'b0;
      end
    end else if (accept) begin
      if (is_md && !by_zero) begin
        state_d  = BUSY;
        count_d  = CW'(WIDTH);
        is_div_d = is_dv;
        neg_lo_d = a_neg ^ b_neg;
        neg_hi_d = a_neg;
        acc_d    = '0;
        mq_d     = is_dv ? a_mag : b_mag;
        md_d     = is_dv ? b_mag : a_mag;
      end else if (by_zero) begin
        out_valid_d = 1'b1;
        lo_d        = '1;
        hi_d        = a;
        zero_d      = 1'b0;
        ovf_d       = 1'b0;
        dbz_d       = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        lo_d        = alu_lo;
        hi_d        = '0;
        zero_d      = (alu_lo == '0) && (op != 4'd15);
        ovf_d       = alu_ovf;
        dbz_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      acc_q       <= '0;
      mq_q        <= '0;
      md_q        <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      is_div_q    <= is_div_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      acc_q       <= acc_d;
      mq_q        <= mq_d;
      md_q        <= md_d;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_lo    = lo_q;
  assign io.out_hi    = hi_q;
  assign io.out_zero  = zero_q;
  assign io.out_ovf   = ovf_q;
  assign io.out_dbz   = dbz_q;
  assign busy         = (state_q == BUSY);
endmodule

// File: tb/tb_alu_mdu_unit.sv
// tb_alu_mdu_unit: directed plus random checks of alu_mdu_unit
// against a 64-bit arithmetic reference model
module tb_alu_mdu_unit;
  logic clk;
  logic resetn;
  logic flush;
  logic busy;

  alu_mdu_unit_if #(.WIDTH(32)) io ();

  alu_mdu_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .busy   (busy),
    .io     (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        dbz;
  } res_t;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic res_t ref_model(input logic [3:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    res_t            r;
    longint          sa, sb, r64;
    longint unsigned ua, ub, p;
    int              sh;
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b[4:0]);
    case (op)
      4'd0: begin
        r64 = sa + sb;
        r.lo = r64[31:0];
        r.ovf = (r64 > 64'sd2147483647) || (r64 < -64'sd2147483648);
      end
      4'd1: begin
        r64 = sa - sb;
        r.lo = r64[31:0];
        r.ovf = (r64 > 64'sd2147483647) || (r64 < -64'sd2147483648);
      end
      4'd2: r.lo = a & b;
      4'd3: r.lo = a | b;
      4'd4: r.lo = a ^ b;
      4'd5: r.lo = ~(a | b);
      4'd6: r.lo = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: r.lo = (ua < ub) ? 32'd1 : 32'd0;
      4'd8: r.lo = a << sh;
      4'd9: r.lo = a >> sh;
      4'd10: begin
        r64 = sa >>> sh;
        r.lo = r64[31:0];
      end
      4'd11: begin
        p = ua * ub;
        r.lo = p[31:0];
        r.hi = p[63:32];
      end
      4'd12: begin
        r64 = sa * sb;
        r.lo = r64[31:0];
        r.hi = r64[63:32];
      end
      4'd13, 4'd14: begin
        if (b == 32'd0) begin
          r.lo = 32'hFFFF_FFFF;
          r.hi = a;
          r.dbz = 1'b1;
        end else if (op == 4'd13) begin
          p = ua / ub;
          r.lo = p[31:0];
          p = ua % ub;
          r.hi = p[31:0];
        end else begin
          r64 = sa / sb;
          r.lo = r64[31:0];
          r64 = sa % sb;
          r.hi = r64[31:0];
        end
      end
      default: r = '0;
    endcase
    r.zero = (r.lo == 32'd0) && (op != 4'd15) && !r.dbz;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, "_lo"}, io.out_lo, e.lo);
    chk({tag, "_hi"}, io.out_hi, e.hi);
    chk({tag, "_flags"}, {io.out_zero, io.out_ovf, io.out_dbz},
        {e.zero, e.ovf, e.dbz});
  endtask

  // issue one op, wait for its result, optionally hold it for `stall` cycles
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int stall);
    res_t e;
    int   edges;
    int   bcnt;
    int   exp_edges;
    e = ref_model(op, a, b);
    exp_edges = (op >= 4'd11 && op <= 4'd14 &&
                 !(op >= 4'd13 && b == 32'd0)) ? 32 : 0;
    io.in_op = op;
    io.in_a = a;
    io.in_b = b;
    io.in_valid = 1'b1;
    io.out_ready = (stall == 0);
    #1;
    chk({tag, "_in_ready"}, io.in_ready, 1);
    step();
    io.in_valid = 1'b0;
    edges = 0;
    bcnt = 0;
    while (!io.out_valid && edges < 200) begin
      if (busy) bcnt++;
      if (edges == 0) chk({tag, "_rdy_busy"}, io.in_ready, 0);
      step();
      edges++;
    end
    chk({tag, "_latency"}, edges, exp_edges);
    chk({tag, "_busy_cycles"}, bcnt, exp_edges);
    chk({tag, "_busy_end"}, busy, 0);
    chk_res(tag, e);
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_hold_valid"}, io.out_valid, 1);
      chk({tag, "_hold_rdy"}, io.in_ready, 0);
      chk({tag, "_hold_lo"}, io.out_lo, e.lo);
      step();
    end
    io.out_ready = 1'b1;
    step();
    chk({tag, "_drained"}, io.out_valid, 0);
  endtask

  function automatic logic [31:0] pick();
    int k;
    k = int'($urandom_range(0, 5));
    case (k)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired errors=%0d of %0d checks", errs, checks);
    $fatal(1);
  end

  initial begin
    res_t e;
    errs = 0;
    checks = 0;
    resetn = 1'b0;
    flush = 1'b0;
    io.in_valid = 1'b0;
    io.in_op = '0;
    io.in_a = '0;
    io.in_b = '0;
    io.out_ready = 1'b1;
    #12;
    chk("rst_valid", io.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk_res("rst", res_t'({32'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
    resetn = 1'b1;
    step();
    chk("rst_in_ready", io.in_ready, 1);

    // back-to-back ALU sweep, one result per cycle
    io.in_a = 32'h30;
    io.in_b = 32'h3E;
    io.in_valid = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      io.in_op = 4'(i);
      #1;
      chk("sweep_in_ready", io.in_ready, 1);
      step();
      chk("sweep_valid", io.out_valid, 1);
      chk_res("sweep", ref_model(4'(i), 32'h30, 32'h3E));
    end
    io.in_valid = 1'b0;
    step();
    chk("sweep_drained", io.out_valid, 0);

    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 0);
    run_op("sub_zero", 4'd1, 32'd5, 32'd5, 0);
    run_op("mult", 4'd12, 32'hFFFF_FFFE, 32'd3, 0);
    run_op("multu", 4'd11, 32'hFFFF_FFFE, 32'd3, 0);
    run_op("div", 4'd14, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_dbz", 4'd13, 32'd7, 32'd0, 0);
    run_op("div_min", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("op15", 4'd15, 32'h1234, 32'h5678, 0);
    run_op("add_bp", 4'd0, 32'h30, 32'h3E, 5);

    // result held, then consumed in the same cycle a new op loads
    io.in_op = 4'd0;
    io.in_a = 32'd9;
    io.in_b = 32'd1;
    io.in_valid = 1'b1;
    io.out_ready = 1'b0;
    step();
    io.in_valid = 1'b0;
    step();
    step();
    chk("bp2_hold_lo", io.out_lo, 32'd10);
    chk("bp2_hold_rdy", io.in_ready, 0);
    io.in_op = 4'd1;
    io.in_a = 32'd5;
    io.in_b = 32'd5;
    io.in_valid = 1'b1;
    io.out_ready = 1'b1;
    #1;
    chk("bp2_in_ready", io.in_ready, 1);
    step();
    io.in_valid = 1'b0;
    chk("bp2_valid", io.out_valid, 1);
    chk_res("bp2", ref_model(4'd1, 32'd5, 32'd5));
    step();

    // flush mid-multiply
    io.in_op = 4'd12;
    io.in_a = 32'd123;
    io.in_b = 32'd456;
    io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    repeat (9) step();
    chk("flush_busy_before", busy, 1);
    flush = 1'b1;
    io.in_valid = 1'b1;
    #1;
    chk("flush_in_ready", io.in_ready, 0);
    step();
    flush = 1'b0;
    io.in_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", io.out_valid, 0);
    repeat (40) step();
    chk("flush_no_result", io.out_valid, 0);

    // reset mid-multiply
    io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    repeat (9) step();
    resetn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", io.out_valid, 0);
    chk_res("arst", res_t'({32'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
    #7;
    resetn = 1'b1;
    step();
    chk("arst_in_ready", io.in_ready, 1);
    repeat (40) step();
    chk("arst_no_result", io.out_valid, 0);

    for (int n = 0; n < 80; n++) begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra = pick();
      rb = pick();
      run_op("rand", rop, ra, rb, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
